alu_mdu_ctrl: RTL and testbench
===============================

Name: alu_mdu_ctrl

Overview:
Parametrised EX-stage ALU control and multiply/divide sequencer for the MIPS pipeline. It decodes the 3-bit ALUOp class plus funct into the 5-bit ALU operation code, and adds a multi-cycle MDU with architectural HI/LO registers (MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO). It also generates a pipeline stall while an MDU operation is in flight.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width (even, >=8)
CNT_W, $clog2(DATA_WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
alu_op  in  3  ALUOp class {ALUOp1,ALUOp2,ALUOp3}
funct  in  6  R-type funct field
valid  in  1  EX instruction valid
flush  in  1  EX instruction squashed this cycle
rs_val  in  DATA_WIDTH  rs operand
rt_val  in  DATA_WIDTH  rt operand
alu_signal  out  5  ALU operation code (combinational)
mdu_busy  out  1  MDU operation in flight
stall  out  1  hold IF/ID/EX this cycle
mdu_rdata  out  DATA_WIDTH  HI for MFHI, LO for MFLO, else 0 (combinational)
hi  out  DATA_WIDTH  HI register
lo  out  DATA_WIDTH  LO register

Behaviour:
- Reset, asynchronous on rstn low: state=IDLE, mdu_busy=0, hi=0, lo=0, counter=0, operand and sign registers=0. stall, alu_signal and mdu_rdata are combinational; with reset asserted and IDLE state, stall=0.
- Decode (combinational, fully specified, no latches):
  - 000 -> ADD; 010 -> SUB; 001 -> SLT; 011 -> ADD; 101 -> LUI; 110 -> OR; 111 -> NOP.
  - 100 -> funct table: ADD/ADDU->ADDU, SUB->SUB, SUBU->SUBU, AND, OR, XOR, NOR->NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV.
  - MDU functs and any unknown funct -> NOP.
- mdu_cls = valid & alu_op==100 & funct in {MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO}.
- stall = mdu_cls & mdu_busy. Non-MDU instructions never stall and overlap with a running op.
- Accept = mdu_cls & !mdu_busy & !flush. A flushed instruction has no effect. Flush never aborts an in-flight op.
- FSM states IDLE, MUL, DIV.
  - IDLE: on accepted MULT/MULTU -> MUL; on DIV/DIVU -> DIV. Both latch abs/raw operands and result signs, counter=0, mdu_busy=1 at the same edge.
  - MTHI/MTLO write hi/lo from rs_val at the accept edge; stay IDLE.
  - MFHI/MFLO: mdu_rdata valid in the accept cycle; no state change.
- MUL: iterative shift-add, one bit per cycle, DATA_WIDTH cycles. On the final edge write the 2*DATA_WIDTH product (negated if signs differ, signed op only): hi=upper, lo=lower. mdu_busy=0 at the same edge; -> IDLE.
- DIV: restoring radix-2, DATA_WIDTH cycles, unsigned on magnitudes. Final edge: lo=quotient, hi=remainder. Signed fix-up: quotient negated if signs differ; remainder takes the dividend's sign.
  - Divisor==0: lo={DATA_WIDTH{1}}, hi=dividend (raw rs).
  - Signed MIN/-1: lo=MIN, hi=0.
- Latency: accept at edge E0; mdu_busy high during cycles E0..E(N); hi/lo updated and busy cleared at edge EN. N=DATA_WIDTH. An MFHI/MFLO stalled during busy proceeds in the cycle after EN and reads the new value.
- Reset mid-operation aborts immediately; hi/lo return to 0.

Optional Feature:
- Macro MDU_FAST_MUL_EN.
- Defined: MUL state completes in 1 cycle using a combinational multiplier (N=1 for MULT/MULTU). Divide is unchanged.
- Undefined: iterative multiply, N=DATA_WIDTH.
- Results must be bit-identical in both builds.

Decomposition:
- Shared package/defines: ALUOp_* 5-bit codes (add ALUOp_NOR, ALUOp_SLLV, ALUOp_SRLV, ALUOp_SRAV, ALUOp_NOP), INSTR_*_FUNCT codes including MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO, and the FSM state encoding.
- One sub-module: mdu_seq_core (iterative mul/div datapath, counter, sign fix-up). The top holds decode, stall/accept logic and HI/LO.

Test Plan:
- Decode sweep: alu_op=100, funct=NOR -> ALUOp_NOR; alu_op=100, funct=0x3F -> ALUOp_NOP; alu_op=101 -> ALUOp_LUI; no X on alu_signal for any input.
- MULT rs=-3, rt=7 (W=32) -> mdu_busy for 32 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB. With MDU_FAST_MUL_EN: same result after 1 cycle.
- DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 5/0 -> lo=0xFFFFFFFF, hi=5.
- MFLO issued 3 cycles after a DIV start -> stall=1 until the completion edge; the next cycle mdu_rdata=new lo, stall=0. An ADDU in between is not stalled.
- MULT with flush=1 -> no state change, busy stays 0. MTHI rs=0xA5A5A5A5 -> hi=0xA5A5A5A5 after 1 edge.
- Assert rstn=0 mid-DIV -> busy=0, hi=lo=0 asynchronously; after release a new MULT 2*3 -> lo=6, hi=0.

Source files
------------

// File: rtl/alu_mdu_ctrl_pkg.sv
// Shared ALU operation codes, R-type funct codes, MDU FSM encoding and decode helpers
// for the EX-stage ALU control / MDU sequencer (optional MDU_FAST_MUL_EN lives in the core).
package alu_mdu_ctrl_pkg;

    localparam int unsigned ALU_SIG_W = 5;
    localparam int unsigned ALUOP_W   = 3;
    localparam int unsigned FUNCT_W   = 6;

    localparam logic [ALU_SIG_W-1:0] ALUOp_ADD  = 5'd0;
    localparam logic [ALU_SIG_W-1:0] ALUOp_ADDU = 5'd1;
    localparam logic [ALU_SIG_W-1:0] ALUOp_SUB  = 5'd2;
    localparam logic [ALU_SIG_W-1:0] ALUOp_SUBU = 5'd3;
    localparam logic [ALU_SIG_W-1:0] ALUOp_AND  = 5'd4;
    localparam logic [ALU_SIG_W-1:0] ALUOp_OR   = 5'd5;
    localparam logic [ALU_SIG_W-1:0] ALUOp_XOR  = 5'd6;
    localparam logic [ALU_SIG_W-1:0] ALUOp_NOR  = 5'd7;
    localparam logic [ALU_SIG_W-1:0] ALUOp_SLT  = 5'd8;
    localparam logic [ALU_SIG_W-1:0] ALUOp_SLTU = 5'd9;
    localparam logic [ALU_SIG_W-1:0] ALUOp_SLL  = 5'd10;
    localparam logic [ALU_SIG_W-1:0] ALUOp_SRL  = 5'd11;
    localparam logic [ALU_SIG_W-1:0] ALUOp_SRA  = 5'd12;
    localparam logic [ALU_SIG_W-1:0] ALUOp_SLLV = 5'd13;
    localparam logic [ALU_SIG_W-1:0] ALUOp_SRLV = 5'd14;
    localparam logic [ALU_SIG_W-1:0] ALUOp_SRAV = 5'd15;
    localparam logic [ALU_SIG_W-1:0] ALUOp_LUI  = 5'd16;
    localparam logic [ALU_SIG_W-1:0] ALUOp_NOP  = 5'd31;

    localparam logic [ALUOP_W-1:0] ALUOP_CLS_RTYPE = 3'b100;

    localparam logic [FUNCT_W-1:0] INSTR_SLL_FUNCT   = 6'h00;
    localparam logic [FUNCT_W-1:0] INSTR_SRL_FUNCT   = 6'h02;
    localparam logic [FUNCT_W-1:0] INSTR_SRA_FUNCT   = 6'h03;
    localparam logic [FUNCT_W-1:0] INSTR_SLLV_FUNCT  = 6'h04;
    localparam logic [FUNCT_W-1:0] INSTR_SRLV_FUNCT  = 6'h06;
    localparam logic [FUNCT_W-1:0] INSTR_SRAV_FUNCT  = 6'h07;
    localparam logic [FUNCT_W-1:0] INSTR_MFHI_FUNCT  = 6'h10;
    localparam logic [FUNCT_W-1:0] INSTR_MTHI_FUNCT  = 6'h11;
    localparam logic [FUNCT_W-1:0] INSTR_MFLO_FUNCT  = 6'h12;
    localparam logic [FUNCT_W-1:0] INSTR_MTLO_FUNCT  = 6'h13;
    localparam logic [FUNCT_W-1:0] INSTR_MULT_FUNCT  = 6'h18;
    localparam logic [FUNCT_W-1:0] INSTR_MULTU_FUNCT = 6'h19;
    localparam logic [FUNCT_W-1:0] INSTR_DIV_FUNCT   = 6'h1A;
    localparam logic [FUNCT_W-1:0] INSTR_DIVU_FUNCT  = 6'h1B;
    localparam logic [FUNCT_W-1:0] INSTR_ADD_FUNCT   = 6'h20;
    localparam logic [FUNCT_W-1:0] INSTR_ADDU_FUNCT  = 6'h21;
    localparam logic [FUNCT_W-1:0] INSTR_SUB_FUNCT   = 6'h22;
    localparam logic [FUNCT_W-1:0] INSTR_SUBU_FUNCT  = 6'h23;
    localparam logic [FUNCT_W-1:0] INSTR_AND_FUNCT   = 6'h24;
    localparam logic [FUNCT_W-1:0] INSTR_OR_FUNCT    = 6'h25;
    localparam logic [FUNCT_W-1:0] INSTR_XOR_FUNCT   = 6'h26;
    localparam logic [FUNCT_W-1:0] INSTR_NOR_FUNCT   = 6'h27;
    localparam logic [FUNCT_W-1:0] INSTR_SLT_FUNCT   = 6'h2A;
    localparam logic [FUNCT_W-1:0] INSTR_SLTU_FUNCT  = 6'h2B;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2
    } mdu_state_e;

    function automatic logic is_mdu_funct(input logic [FUNCT_W-1:0] f);
        case (f)
            INSTR_MULT_FUNCT, INSTR_MULTU_FUNCT, INSTR_DIV_FUNCT, INSTR_DIVU_FUNCT,
            INSTR_MFHI_FUNCT, INSTR_MFLO_FUNCT, INSTR_MTHI_FUNCT, INSTR_MTLO_FUNCT:
                is_mdu_funct = 1'b1;
            default: is_mdu_funct = 1'b0;
        endcase
    endfunction

    // ALUOp class + funct to ALU operation code; MDU and unknown functs map to NOP
    function automatic logic [ALU_SIG_W-1:0] decode_alu(input logic [ALUOP_W-1:0] op,
                                                         input logic [FUNCT_W-1:0] f);
        logic [ALU_SIG_W-1:0] sig;
        sig = ALUOp_NOP;
        case (op)
            3'b000: sig = ALUOp_ADD;
            3'b010: sig = ALUOp_SUB;
            3'b001: sig = ALUOp_SLT;
            3'b011: sig = ALUOp_ADD;
            3'b101: sig = ALUOp_LUI;
            3'b110: sig = ALUOp_OR;
            3'b100: begin
                case (f)
                    INSTR_ADD_FUNCT, INSTR_ADDU_FUNCT: sig = ALUOp_ADDU;
                    INSTR_SUB_FUNCT:  sig = ALUOp_SUB;
                    INSTR_SUBU_FUNCT: sig = ALUOp_SUBU;
                    INSTR_AND_FUNCT:  sig = ALUOp_AND;
                    INSTR_OR_FUNCT:   sig = ALUOp_OR;
                    INSTR_XOR_FUNCT:  sig = ALUOp_XOR;
                    INSTR_NOR_FUNCT:  sig = ALUOp_NOR;
                    INSTR_SLT_FUNCT:  sig = ALUOp_SLT;
                    INSTR_SLTU_FUNCT: sig = ALUOp_SLTU;
                    INSTR_SLL_FUNCT:  sig = ALUOp_SLL;
                    INSTR_SRL_FUNCT:  sig = ALUOp_SRL;
                    INSTR_SRA_FUNCT:  sig = ALUOp_SRA;
                    INSTR_SLLV_FUNCT: sig = ALUOp_SLLV;
                    INSTR_SRLV_FUNCT: sig = ALUOp_SRLV;
                    INSTR_SRAV_FUNCT: sig = ALUOp_SRAV;
                    default:          sig = ALUOp_NOP;
                endcase
            end
            default: sig = ALUOp_NOP;
        endcase
        return sig;
    endfunction

endpackage

// File: rtl/mdu_seq_core.sv
// Multi-cycle multiply/divide datapath: shift-add multiply, restoring divide, sign fix-up.
// Define MDU_FAST_MUL_EN to finish multiplies in one cycle with a combinational multiplier.
module mdu_seq_core
    import alu_mdu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_start,
    input  logic                  i_is_div,
    input  logic                  i_is_signed,
    input  logic [DATA_WIDTH-1:0] i_rs,
    input  logic [DATA_WIDTH-1:0] i_rt,
    output logic                  o_busy,
    output logic                  o_done_c,
    output logic [DATA_WIDTH-1:0] o_hi_c,
    output logic [DATA_WIDTH-1:0] o_lo_c
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    mdu_state_e       r_state;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_a;       // multiplicand / divisor magnitude
    logic [W-1:0]     r_b;       // multiplier / dividend magnitude, shifts into product lo / quotient
    logic [W-1:0]     r_acc;     // partial product hi / partial remainder
    logic [W-1:0]     r_rs_raw;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_rs_neg, w_rt_neg;
    logic [W-1:0]     w_rs_abs, w_rt_abs;
    logic [W:0]       w_mul_sum;
    logic [W-1:0]     w_mul_hi_n, w_mul_lo_n;
    logic [W:0]       w_shift, w_sub;
    logic             w_ge;
    logic [W-1:0]     w_div_rem_n, w_div_q_n;
    logic [2*W-1:0]   w_prod_mag, w_prod;
    logic             w_last, w_mul_last;

    assign w_rs_neg = i_is_signed & i_rs[W-1];
    assign w_rt_neg = i_is_signed & i_rt[W-1];
    assign w_rs_abs = w_rs_neg ? (~i_rs + W'(1)) : i_rs;
    assign w_rt_abs = w_rt_neg ? (~i_rt + W'(1)) : i_rt;

    // One multiplier bit per cycle: add, then shift {acc, b} right by one
    assign w_mul_sum  = {1'b0, r_acc} + {1'b0, (r_b[0] ? r_a : {W{1'b0}})};
    assign w_mul_hi_n = w_mul_sum[W:1];
    assign w_mul_lo_n = {w_mul_sum[0], r_b[W-1:1]};

    // One quotient bit per cycle: shift in next dividend bit, subtract if it fits
    assign w_shift     = {r_acc, r_b[W-1]};
    assign w_ge        = (w_shift >= {1'b0, r_a});
    assign w_sub       = w_shift - {1'b0, r_a};
    assign w_div_rem_n = w_ge ? W'(w_sub) : W'(w_shift);
    assign w_div_q_n   = {r_b[W-2:0], w_ge};

    assign w_last = (r_cnt == LAST_CNT);

`ifdef MDU_FAST_MUL_EN
    assign w_prod_mag = (2*W)'(r_a) * (2*W)'(r_b);
    assign w_mul_last = 1'b1;
`else
    assign w_prod_mag = {w_mul_hi_n, w_mul_lo_n};
    assign w_mul_last = w_last;
`endif

    assign w_prod = r_neg_q ? (~w_prod_mag + (2*W)'(1)) : w_prod_mag;

    assign o_done_c = ((r_state == MDU_MUL) && w_mul_last) || ((r_state == MDU_DIV) && w_last);
    assign o_busy   = r_busy;

    // Final-edge results, valid only while o_done_c is high
    always_comb begin
        o_hi_c = '0;
        o_lo_c = '0;
        case (r_state)
            MDU_MUL: {o_hi_c, o_lo_c} = w_prod;
            MDU_DIV: begin
                if (r_a == '0) begin
                    o_lo_c = '1;
                    o_hi_c = r_rs_raw;
                end else begin
                    o_lo_c = r_neg_q ? (~w_div_q_n + W'(1)) : w_div_q_n;
                    o_hi_c = r_neg_r ? (~w_div_rem_n + W'(1)) : w_div_rem_n;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= MDU_IDLE;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_rs_raw <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            case (r_state)
                MDU_IDLE: begin
                    if (i_start) begin
                        r_state  <= i_is_div ? MDU_DIV : MDU_MUL;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_a      <= i_is_div ? w_rt_abs : w_rs_abs;
                        r_b      <= i_is_div ? w_rs_abs : w_rt_abs;
                        r_acc    <= '0;
                        r_rs_raw <= i_rs;
                        r_neg_q  <= w_rs_neg ^ w_rt_neg;
                        r_neg_r  <= w_rs_neg;
                    end
                end
                MDU_MUL, MDU_DIV: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_state == MDU_MUL) begin
                        r_acc <= w_mul_hi_n;
                        r_b   <= w_mul_lo_n;
                    end else begin
                        r_acc <= w_div_rem_n;
                        r_b   <= w_div_q_n;
                    end
                    if (o_done_c) begin
                        r_state <= MDU_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= MDU_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_mdu_ctrl.sv
// EX-stage ALU control decode plus MDU issue/stall control and architectural HI/LO.
// Build option MDU_FAST_MUL_EN (see mdu_seq_core) selects a single-cycle multiply.
module alu_mdu_ctrl
    import alu_mdu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ALUOP_W-1:0]    alu_op,
    input  logic [FUNCT_W-1:0]    funct,
    input  logic                  valid,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] rs_val,
    input  logic [DATA_WIDTH-1:0] rt_val,
    output logic [ALU_SIG_W-1:0]  alu_signal,
    output logic                  mdu_busy,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] mdu_rdata,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    logic [DATA_WIDTH-1:0] r_hi, r_lo;
    logic                  w_rtype, w_mdu_cls, w_accept, w_start, w_is_div, w_is_signed;
    logic                  w_busy, w_done;
    logic [DATA_WIDTH-1:0] w_res_hi, w_res_lo;

    assign alu_signal = decode_alu(alu_op, funct);

    assign w_rtype   = valid && (alu_op == ALUOP_CLS_RTYPE);
    assign w_mdu_cls = w_rtype && is_mdu_funct(funct);
    // Only MDU-class instructions wait on the sequencer; everything else overlaps
    assign stall     = w_mdu_cls && w_busy;
    assign w_accept  = w_mdu_cls && !w_busy && !flush;

    assign w_start     = w_accept && ((funct == INSTR_MULT_FUNCT) || (funct == INSTR_MULTU_FUNCT) ||
                                      (funct == INSTR_DIV_FUNCT)  || (funct == INSTR_DIVU_FUNCT));
    assign w_is_div    = (funct == INSTR_DIV_FUNCT)  || (funct == INSTR_DIVU_FUNCT);
    assign w_is_signed = (funct == INSTR_MULT_FUNCT) || (funct == INSTR_DIV_FUNCT);

    mdu_seq_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk         (clk),
        .rstn        (rstn),
        .i_start     (w_start),
        .i_is_div    (w_is_div),
        .i_is_signed (w_is_signed),
        .i_rs        (rs_val),
        .i_rt        (rt_val),
        .o_busy      (w_busy),
        .o_done_c    (w_done),
        .o_hi_c      (w_res_hi),
        .o_lo_c      (w_res_lo)
    );

    // HI/LO: sequencer result on its final edge, else MTHI/MTLO (never both in one cycle)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (w_accept) begin
            if (funct == INSTR_MTHI_FUNCT) r_hi <= rs_val;
            if (funct == INSTR_MTLO_FUNCT) r_lo <= rs_val;
        end
    end

    always_comb begin
        mdu_rdata = '0;
        if (w_rtype && (funct == INSTR_MFHI_FUNCT)) mdu_rdata = r_hi;
        if (w_rtype && (funct == INSTR_MFLO_FUNCT)) mdu_rdata = r_lo;
    end

    assign mdu_busy = w_busy;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Self-checking bench for alu_mdu_ctrl: decode table, directed MDU corners, random mul/div vs model.
module tb_alu_mdu_ctrl;
    import alu_mdu_ctrl_pkg::*;

    localparam int unsigned W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_N = 1;
`else
    localparam int MUL_N = 32;
`endif
    localparam int DIV_N = 32;

    logic         clk, rstn, valid, flush;
    logic [2:0]   alu_op;
    logic [5:0]   funct;
    logic [W-1:0] rs_val, rt_val, mdu_rdata, hi, lo;
    logic [4:0]   alu_signal;
    logic         mdu_busy, stall;

    int n_tests, n_fail;

    alu_mdu_ctrl #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rstn(rstn), .alu_op(alu_op), .funct(funct), .valid(valid), .flush(flush),
        .rs_val(rs_val), .rt_val(rt_val), .alu_signal(alu_signal), .mdu_busy(mdu_busy),
        .stall(stall), .mdu_rdata(mdu_rdata), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [5:0] f;
        logic [4:0] exp;
    } dec_vec_t;

    dec_vec_t dv[26];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        valid  = v;
        alu_op = 3'b100;
        funct  = f;
        rs_val = a;
        rt_val = b;
    endtask

    // Architectural MIPS multiply/divide result, returned as {hi, lo}
    function automatic logic [63:0] mdu_model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, p;
        int     qa, qb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        qa = $signed(a);
        qb = $signed(b);
        r  = '0;
        case (f)
            INSTR_MULT_FUNCT: begin
                p = sa * sb;
                r = 64'(p);
            end
            INSTR_MULTU_FUNCT: r = {32'd0, a} * {32'd0, b};
            INSTR_DIV_FUNCT: begin
                if (b == 0)                                 r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == '1)     r = {32'd0, 32'h8000_0000};
                else                                        r = {32'(qa % qb), 32'(qa / qb)};
            end
            INSTR_DIVU_FUNCT: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else        r = {a % b, a / b};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Issue one MDU op, check busy window length and final HI/LO against the model
    task automatic run_op(input string name, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] exp;
        int n, cyc;
        exp = mdu_model(f, a, b);
        n   = (f == INSTR_MULT_FUNCT || f == INSTR_MULTU_FUNCT) ? MUL_N : DIV_N;
        drive(1'b1, f, a, b);
        tick();
        valid = 1'b0;
        chk({name, " busy_after_accept"}, 64'(mdu_busy), 64'd1);
        cyc = 0;
        while (mdu_busy && cyc < 200) begin
            tick();
            cyc++;
        end
        chk({name, " latency"}, 64'(cyc), 64'(n));
        chk({name, " hi"}, 64'(hi), 64'(exp[63:32]));
        chk({name, " lo"}, 64'(lo), 64'(exp[31:0]));
    endtask

    initial begin
        logic [W-1:0] save_hi, save_lo, ra, rb;
        logic [5:0]   rf;
        int           bad, cnt;

        n_tests = 0;
        n_fail  = 0;
        rstn = 1'b0;
        valid = 1'b0;
        flush = 1'b0;
        alu_op = 3'b000;
        funct = 6'h00;
        rs_val = '0;
        rt_val = '0;

        dv[0]  = '{3'b000, 6'h00, ALUOp_ADD};
        dv[1]  = '{3'b010, 6'h00, ALUOp_SUB};
        dv[2]  = '{3'b001, 6'h2A, ALUOp_SLT};
        dv[3]  = '{3'b011, 6'h00, ALUOp_ADD};
        dv[4]  = '{3'b101, 6'h00, ALUOp_LUI};
        dv[5]  = '{3'b110, 6'h25, ALUOp_OR};
        dv[6]  = '{3'b111, 6'h20, ALUOp_NOP};
        dv[7]  = '{3'b100, 6'h20, ALUOp_ADDU};
        dv[8]  = '{3'b100, 6'h21, ALUOp_ADDU};
        dv[9]  = '{3'b100, 6'h22, ALUOp_SUB};
        dv[10] = '{3'b100, 6'h23, ALUOp_SUBU};
        dv[11] = '{3'b100, 6'h24, ALUOp_AND};
        dv[12] = '{3'b100, 6'h25, ALUOp_OR};
        dv[13] = '{3'b100, 6'h26, ALUOp_XOR};
        dv[14] = '{3'b100, 6'h27, ALUOp_NOR};
        dv[15] = '{3'b100, 6'h2A, ALUOp_SLT};
        dv[16] = '{3'b100, 6'h2B, ALUOp_SLTU};
        dv[17] = '{3'b100, 6'h00, ALUOp_SLL};
        dv[18] = '{3'b100, 6'h02, ALUOp_SRL};
        dv[19] = '{3'b100, 6'h03, ALUOp_SRA};
        dv[20] = '{3'b100, 6'h04, ALUOp_SLLV};
        dv[21] = '{3'b100, 6'h06, ALUOp_SRLV};
        dv[22] = '{3'b100, 6'h07, ALUOp_SRAV};
        dv[23] = '{3'b100, 6'h3F, ALUOp_NOP};
        dv[24] = '{3'b100, 6'h18, ALUOp_NOP};
        dv[25] = '{3'b100, 6'h12, ALUOp_NOP};

        #2;
        chk("reset busy", 64'(mdu_busy), 64'd0);
        chk("reset stall", 64'(stall), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        #10;
        rstn = 1'b1;
        tick();

        // Decode table (valid low so nothing reaches the sequencer)
        for (int i = 0; i < 26; i++) begin
            alu_op = dv[i].op;
            funct  = dv[i].f;
            #1;
            chk($sformatf("decode[%0d] op=%b f=%h", i, dv[i].op, dv[i].f), 64'(alu_signal), 64'(dv[i].exp));
        end
        bad = 0;
        for (int op = 0; op < 8; op++) begin
            for (int f = 0; f < 64; f++) begin
                alu_op = 3'(op);
                funct  = 6'(f);
                #1;
                if ($isunknown(alu_signal)) bad++;
            end
        end
        chk("decode no X", 64'(bad), 64'd0);
        chk("rdata idle zero", 64'(mdu_rdata), 64'd0);

        // Directed multiply/divide corners
        run_op("MULT -3*7", INSTR_MULT_FUNCT, 32'hFFFF_FFFD, 32'd7);
        chk("MULT -3*7 hi lit", 64'(hi), 64'hFFFF_FFFF);
        chk("MULT -3*7 lo lit", 64'(lo), 64'hFFFF_FFEB);
        run_op("DIVU 100/7", INSTR_DIVU_FUNCT, 32'd100, 32'd7);
        chk("DIVU lit lo", 64'(lo), 64'd14);
        chk("DIVU lit hi", 64'(hi), 64'd2);
        run_op("DIV -7/2", INSTR_DIV_FUNCT, 32'hFFFF_FFF9, 32'd2);
        chk("DIV -7/2 lit lo", 64'(lo), 64'hFFFF_FFFD);
        chk("DIV -7/2 lit hi", 64'(hi), 64'hFFFF_FFFF);
        run_op("DIV 5/0", INSTR_DIV_FUNCT, 32'd5, 32'd0);
        chk("DIV 5/0 lit lo", 64'(lo), 64'hFFFF_FFFF);
        chk("DIV 5/0 lit hi", 64'(hi), 64'd5);
        run_op("DIV MIN/-1", INSTR_DIV_FUNCT, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("DIV -9/0", INSTR_DIV_FUNCT, 32'hFFFF_FFF7, 32'd0);
        run_op("MULTU max", INSTR_MULTU_FUNCT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("MULT MIN*MIN", INSTR_MULT_FUNCT, 32'h8000_0000, 32'h8000_0000);
        run_op("DIV 7/-2", INSTR_DIV_FUNCT, 32'd7, 32'hFFFF_FFFE);

        // Random mul/div against the model
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: rf = INSTR_MULT_FUNCT;
                1: rf = INSTR_MULTU_FUNCT;
                2: rf = INSTR_DIV_FUNCT;
                default: rf = INSTR_DIVU_FUNCT;
            endcase
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = '1;
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand[%0d] f=%h a=%h b=%h", i, rf, ra, rb), rf, ra, rb);
        end

        // MFLO issued while a DIV runs stalls until completion; ADDU overlaps freely
        drive(1'b1, INSTR_DIV_FUNCT, 32'd100, 32'd7);
        tick();
        drive(1'b1, INSTR_ADDU_FUNCT, 32'd1, 32'd2);
        #1;
        chk("ADDU during DIV stall", 64'(stall), 64'd0);
        chk("ADDU during DIV decode", 64'(alu_signal), 64'(ALUOp_ADDU));
        tick();
        valid = 1'b0;
        tick();
        tick();
        drive(1'b1, INSTR_MFLO_FUNCT, 32'd0, 32'd0);
        #1;
        chk("MFLO stalled", 64'(stall), 64'd1);
        cnt = 0;
        while (stall && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("MFLO stall length", 64'(cnt), 64'(DIV_N - 3));
        chk("MFLO stall released", 64'(stall), 64'd0);
        chk("MFLO rdata", 64'(mdu_rdata), 64'd14);
        chk("MFLO busy clear", 64'(mdu_busy), 64'd0);
        tick();
        valid = 1'b0;

        // Flushed MULT has no effect
        save_hi = hi;
        save_lo = lo;
        drive(1'b1, INSTR_MULT_FUNCT, 32'd5, 32'd9);
        flush = 1'b1;
        tick();
        valid = 1'b0;
        flush = 1'b0;
        chk("flush busy", 64'(mdu_busy), 64'd0);
        tick();
        chk("flush hi", 64'(hi), 64'(save_hi));
        chk("flush lo", 64'(lo), 64'(save_lo));

        // MTHI/MTLO and MFHI
        drive(1'b1, INSTR_MTHI_FUNCT, 32'hA5A5_A5A5, 32'd0);
        tick();
        chk("MTHI hi", 64'(hi), 64'hA5A5_A5A5);
        chk("MTHI busy", 64'(mdu_busy), 64'd0);
        drive(1'b1, INSTR_MTLO_FUNCT, 32'h1234_5678, 32'd0);
        tick();
        chk("MTLO lo", 64'(lo), 64'h1234_5678);
        chk("MTLO hi kept", 64'(hi), 64'hA5A5_A5A5);
        drive(1'b1, INSTR_MFHI_FUNCT, 32'd0, 32'd0);
        #1;
        chk("MFHI rdata", 64'(mdu_rdata), 64'hA5A5_A5A5);
        chk("MFHI no stall", 64'(stall), 64'd0);
        tick();
        valid = 1'b0;

        // Asynchronous reset in the middle of a divide
        drive(1'b1, INSTR_DIV_FUNCT, 32'd1000, 32'd3);
        tick();
        valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("pre-reset busy", 64'(mdu_busy), 64'd1);
        rstn = 1'b0;
        #1;
        chk("async reset busy", 64'(mdu_busy), 64'd0);
        chk("async reset hi", 64'(hi), 64'd0);
        chk("async reset lo", 64'(lo), 64'd0);
        #3;
        rstn = 1'b1;
        tick();
        run_op("MULT 2*3 after reset", INSTR_MULT_FUNCT, 32'd2, 32'd3);
        chk("post-reset lo lit", 64'(lo), 64'd6);
        chk("post-reset hi lit", 64'(hi), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
